// File: rtl/pending_req_scheduler.sv
// Sticky 8-source request collector with a fixed-priority, one-at-a-time
// grant offer (valid/ready) and a saturating counter of coalesced requests.
module pending_req_scheduler #(
  parameter int unsigned DROP_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            req_pulse,
  input  logic                  clr,
  output logic                  gnt_valid,
  output logic [2:0]            gnt_idx,
  input  logic                  gnt_ready,
  output logic [7:0]            pending,
  output logic                  any_pending,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  localparam int unsigned NUM_SRC = 8;
  localparam int unsigned SUM_W   = DROP_CNT_W + 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_OFFER = 1'b1
  } state_t;

  state_t                r_state;
  logic                  r_gnt_valid;
  logic [2:0]            r_gnt_idx;
  logic [NUM_SRC-1:0]    r_pending;
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  state_t                w_state_nxt;
  logic                  w_gnt_valid_nxt;
  logic [2:0]            w_idx_nxt;
  logic [NUM_SRC-1:0]    w_pend_nxt;
  logic [DROP_CNT_W-1:0] w_drop_nxt;

  logic                  w_hs;
  logic [NUM_SRC-1:0]    w_grant_mask;
  logic [NUM_SRC-1:0]    w_drops;
  logic [NUM_SRC-1:0]    w_pend_upd;
  logic [3:0]            w_drop_num;
  logic [SUM_W-1:0]      w_drop_sum;
  logic [SUM_W-1:0]      w_drop_max;
  logic [DROP_CNT_W-1:0] w_drop_sat;

  // Lowest set bit wins; scanning downward lets the lowest index overwrite last.
  function automatic logic [2:0] lowest_idx(input logic [NUM_SRC-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  always_comb begin
    w_hs         = (r_state == ST_OFFER) && gnt_ready;
    w_grant_mask = w_hs ? (8'd1 << r_gnt_idx) : 8'd0;
    // A repeat request on the bit being granted re-arms it rather than dropping.
    w_drops      = req_pulse & r_pending & ~w_grant_mask;
    w_pend_upd   = (r_pending & ~w_grant_mask) | req_pulse;

    w_drop_num = 4'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_drop_num = w_drop_num + 4'(w_drops[i]);
    end
    w_drop_sum = SUM_W'(r_drop_cnt) + SUM_W'(w_drop_num);
    w_drop_max = SUM_W'({DROP_CNT_W{1'b1}});
    w_drop_sat = (w_drop_sum > w_drop_max) ? {DROP_CNT_W{1'b1}}
                                           : DROP_CNT_W'(w_drop_sum);
  end

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_gnt_idx;
    w_pend_nxt  = w_pend_upd;
    w_drop_nxt  = w_drop_sat;

    if (clr) begin
      w_state_nxt = ST_IDLE;
      w_pend_nxt  = '0;
      w_drop_nxt  = r_drop_cnt;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_pend_upd) begin
            w_state_nxt = ST_OFFER;
            w_idx_nxt   = lowest_idx(w_pend_upd);
          end
        end
        ST_OFFER: begin
          // Offer is frozen until accepted; acceptance may chain straight into the next.
          if (w_hs) begin
            if (|w_pend_upd) begin
              w_state_nxt = ST_OFFER;
              w_idx_nxt   = lowest_idx(w_pend_upd);
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end

    w_gnt_valid_nxt = (w_state_nxt == ST_OFFER);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_gnt_valid <= 1'b0;
      r_gnt_idx   <= 3'd0;
      r_pending   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_gnt_valid <= w_gnt_valid_nxt;
      r_gnt_idx   <= w_idx_nxt;
      r_pending   <= w_pend_nxt;
      r_drop_cnt  <= w_drop_nxt;
    end
  end

  assign gnt_valid   = r_gnt_valid;
  assign gnt_idx     = r_gnt_idx;
  assign pending     = r_pending;
  assign any_pending = |r_pending;
  assign drop_cnt    = r_drop_cnt;

endmodule

// File: doc/pending_req_scheduler.md
PENDING_REQ_SCHEDULER -- requirements
Module: pending_req_scheduler

Interface
REQ-001 Parameter SHALL be: DROP_CNT_W, 8, width of saturating dropped-request counter (legal 4..16).
REQ-002 Port SHALL be: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port SHALL be: rst_n  input  1  synchronous, active-low reset.
REQ-004 Port SHALL be: req_pulse  input  8  request events; bit i high = one request from source i this cycle.
REQ-005 Port SHALL be: clr  input  1  synchronous flush of all pending requests and any open offer.
REQ-006 Port SHALL be: gnt_valid  output  1  grant offer valid.
REQ-007 Port SHALL be: gnt_idx  output  3  index of granted source; meaningful only while gnt_valid=1.
REQ-008 Port SHALL be: gnt_ready  input  1  consumer accepts grant; handshake = gnt_valid & gnt_ready.
REQ-009 Port SHALL be: pending  output  8  registered sticky request vector.
REQ-010 Port SHALL be: any_pending  output  1  OR-reduction of pending.
REQ-011 Port SHALL be: drop_cnt  output  DROP_CNT_W  saturating count of dropped request events.

Function
REQ-012 Block SHALL hold an 8-bit sticky pending register; req_pulse[i]=1 sets pending[i] at the next edge.
REQ-013 Priority SHALL be fixed: lowest set index wins (bit 0 highest priority).
REQ-014 FSM SHALL have two states: IDLE (gnt_valid=0) and OFFER (gnt_valid=1).
REQ-015 IDLE->OFFER SHALL occur at an edge where (pending | req_pulse) != 0; gnt_idx loads the lowest set index of (pending | req_pulse) at that same edge.
REQ-016 Latency: req_pulse on an idle block in cycle N SHALL give gnt_valid=1 with the matching gnt_idx in cycle N+1.
REQ-017 While in OFFER without handshake, gnt_valid and gnt_idx SHALL stay constant, even if a higher-priority request arrives.
REQ-018 On handshake, pending[gnt_idx] SHALL clear at that edge unless req_pulse[gnt_idx] is also high that cycle; set wins, and the new event is not a drop.
REQ-019 On handshake, if (pending with the granted bit cleared per REQ-018) | req_pulse != 0, the FSM SHALL stay in OFFER and load the new lowest index; otherwise it SHALL go to IDLE. This gives back-to-back grants at one per cycle.
REQ-020 A drop SHALL be any bit where req_pulse[i]=1 and pending[i]=1, excluding the granted bit during a handshake. drop_cnt SHALL add the number of dropped bits that cycle (0..8).
REQ-021 drop_cnt SHALL saturate at 2^DROP_CNT_W-1 and never wrap; it clears only on reset.
REQ-022 clr=1 SHALL at the next edge zero pending, force IDLE and gnt_valid=0, and ignore req_pulse and gnt_ready that cycle; drop_cnt is unchanged. Withdrawing an open offer is permitted only via clr.
REQ-023 gnt_valid, gnt_idx, pending and drop_cnt SHALL be registered outputs; any_pending SHALL be combinational from the pending register.
REQ-024 gnt_ready while gnt_valid=0 SHALL have no effect.

Reset
REQ-025 With rst_n=0 at an edge, the block SHALL set: state=IDLE, gnt_valid=0, gnt_idx=0, pending=0, any_pending=0, drop_cnt=0.
REQ-026 Reset SHALL take priority over clr, req_pulse and gnt_ready; reset asserted mid-offer drops the offer with no handshake credited.
REQ-027 The first request SHALL be accepted at the first edge with rst_n=1.

Verification
REQ-028 Idle block, req_pulse=8'h28 for one cycle -> next cycle: gnt_valid=1, gnt_idx=3, pending=8'h28. With gnt_ready=1 held: gnt_idx=5 the following cycle, then gnt_valid=0 and pending=0.
REQ-029 Offer of idx 4 with gnt_ready=0, then req_pulse=8'h01 -> gnt_idx stays 4. Assert gnt_ready -> next grant is idx 0.
REQ-030 pending=8'h04, offer idx 2, handshake with req_pulse=8'h06 -> pending=8'h06, drop_cnt unchanged, next gnt_idx=1. Then req_pulse=8'h06 with no handshake -> drop_cnt +2.
REQ-031 Drive 8'hFF req_pulse repeatedly with gnt_ready=0, DROP_CNT_W=4 -> drop_cnt reaches 15 and holds at 15.
REQ-032 clr during an offer with pending=8'h81 and req_pulse=8'h02 -> next cycle: gnt_valid=0, pending=0, drop_cnt unchanged.
REQ-033 rst_n=0 with clr=1 mid-offer -> all outputs at reset values next cycle. Release reset with req_pulse=8'h80 on the first edge -> gnt_idx=7.
